flit_sink: RTL and testbench

FLIT_SINK -- requirements
Module: flit_sink

---
 rtl/flit_sink_if.sv | 35 +++
 rtl/flit_sink.sv | 141 ++++++++++++++
 tb/tb_flit_sink.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/flit_sink_if.sv
// Purpose: handshake/bus bundle between a router output port and flit_sink.
// Signals:
//   write, data_in, drain_en       : driven by the router/drain side (master)
//   full, almost_full              : occupancy status, driven by the sink (slave)
//   out_valid, out_flit            : popped flit and its one-cycle strobe
//   err_dest, err_seq, overflow    : error pulses and sticky overflow flag
//   flit_count, err_count          : saturating 16-bit statistics
interface flit_sink_if #(
   parameter int unsigned WIDTH = 12
);
   logic             write;
   logic [WIDTH-1:0] data_in;
   logic             drain_en;
   logic             full;
   logic             almost_full;
   logic             out_valid;
   logic [WIDTH-1:0] out_flit;
   logic             err_dest;
   logic             err_seq;
   logic             overflow;
   logic [15:0]      flit_count;
   logic [15:0]      err_count;

   modport master (
      output write, data_in, drain_en,
      input  full, almost_full, out_valid, out_flit, err_dest, err_seq,
             overflow, flit_count, err_count
   );

   modport slave (
      input  write, data_in, drain_en,
      output full, almost_full, out_valid, out_flit, err_dest, err_seq,
             overflow, flit_count, err_count
   );
endinterface

// File: rtl/flit_sink.sv
// Purpose: network-endpoint flit sink. Buffers valid flits in a DEPTH-entry
// FIFO, pops one per cycle when drain_en is high, and checks each popped flit
// for a wrong destination id and (optionally) a per-source sequence break.
// Flit layout: bit0 valid, [2:1] dest, [4:3] src, [WIDTH-1:5] seq.
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high
//   bus (slave)    : write/data_in/drain_en in; full/almost_full (from count),
//                    out_valid/out_flit/err_dest/err_seq (registered on the pop
//                    edge), overflow (sticky), flit_count/err_count (saturating)
// Build option: define FLIT_SINK_SEQCHK_EN to include the per-source sequence
// trackers; without it err_seq is constant 0 and only dest errors are counted.
module flit_sink #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 8,
   parameter logic [1:0]  MY_ID = 2'b00
) (
   input  logic        clk,
   input  logic        reset,
   flit_sink_if.slave  bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = WIDTH - 5;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             out_valid_q, err_dest_q, err_seq_q, overflow_q;
   logic [WIDTH-1:0] out_flit_q;
   logic [15:0]      flit_count_q, err_count_q;

   logic             flit_ok_c, push_c, pop_c;
   logic [WIDTH-1:0] pop_flit_c;
   logic             dest_err_c, seq_err_c;
   logic [15:0]      flit_count_d, err_count_d;
   logic [16:0]      err_sum_c;

   // Admission uses the pre-edge count, so a same-cycle pop never frees a slot.
   assign flit_ok_c  = bus.write & bus.data_in[0];
   assign push_c     = flit_ok_c & (count_q != CW'(DEPTH));
   assign pop_c      = bus.drain_en & (count_q != '0);
   assign pop_flit_c = mem_q[rd_ptr_q];
   assign dest_err_c = pop_c & (pop_flit_c[2:1] != MY_ID);

   assign bus.full        = (count_q == CW'(DEPTH));
   assign bus.almost_full = (count_q >= CW'(DEPTH - 1));

`ifdef FLIT_SINK_SEQCHK_EN
   typedef enum logic {UNSEEN = 1'b0, TRACKING = 1'b1} trk_state_e;

   trk_state_e    trk_q [4];
   trk_state_e    trk_d [4];
   logic [SW-1:0] exp_q [4];
   logic [SW-1:0] exp_d [4];
   logic [1:0]    pop_src_c;
   logic [SW-1:0] pop_seq_c;

   assign pop_src_c = pop_flit_c[4:3];
   assign pop_seq_c = pop_flit_c[WIDTH-1:5];

   // Tracker state registers, one per source id.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            trk_q[i] <= UNSEEN;
            exp_q[i] <= '0;
         end
      end else begin
         trk_q <= trk_d;
         exp_q <= exp_d;
      end
   end

   // Tracker next state: first flit from a source only arms it; afterwards any
   // mismatch flags an error and resynchronises to the observed seq.
   always_comb begin
      trk_d     = trk_q;
      exp_d     = exp_q;
      seq_err_c = 1'b0;
      if (pop_c) begin
         case (trk_q[pop_src_c])
            UNSEEN:   seq_err_c = 1'b0;
            TRACKING: seq_err_c = (pop_seq_c != exp_q[pop_src_c]);
         endcase
         trk_d[pop_src_c] = TRACKING;
         exp_d[pop_src_c] = pop_seq_c + SW'(1);
      end
   end
`else
   assign seq_err_c = 1'b0;
`endif

   // Saturating statistics; both error kinds may land in the same pop.
   always_comb begin
      flit_count_d = flit_count_q;
      if (pop_c && flit_count_q != 16'hFFFF) flit_count_d = flit_count_q + 16'd1;
      err_sum_c   = {1'b0, err_count_q} + 17'(dest_err_c) + 17'(seq_err_c);
      err_count_d = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= bus.data_in;
   end

   // Pointers, occupancy and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_flit_q   <= '0;
         err_dest_q   <= 1'b0;
         err_seq_q    <= 1'b0;
         overflow_q   <= 1'b0;
         flit_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q      <= count_q + CW'(push_c) - CW'(pop_c);
         out_valid_q  <= pop_c;
         if (pop_c) out_flit_q <= pop_flit_c;
         err_dest_q   <= dest_err_c;
         err_seq_q    <= seq_err_c;
         overflow_q   <= overflow_q | (flit_ok_c & bus.full);
         flit_count_q <= flit_count_d;
         err_count_q  <= err_count_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_flit   = out_flit_q;
   assign bus.err_dest   = err_dest_q;
   assign bus.err_seq    = err_seq_q;
   assign bus.overflow   = overflow_q;
   assign bus.flit_count = flit_count_q;
   assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_flit_sink.sv
// Purpose: self-checking bench for flit_sink (WIDTH=12, DEPTH=8, MY_ID=0).
// A queue-based model predicts every output each cycle; directed scenarios add
// literal expectations. Honors FLIT_SINK_SEQCHK_EN for the seq-check build.
module tb_flit_sink;
   localparam int unsigned WIDTH = 12;
   localparam int unsigned DEPTH = 8;
   localparam logic [1:0]  MY_ID = 2'b00;
`ifdef FLIT_SINK_SEQCHK_EN
   localparam int SEQCHK = 1;
`else
   localparam int SEQCHK = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   flit_sink_if #(.WIDTH(WIDTH)) bus ();

   flit_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MY_ID(MY_ID)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function automatic logic [11:0] mk(input int seq, input int src,
                                      input int dest, input bit v);
      return {7'(seq), 2'(src), 2'(dest), v};
   endfunction

   // Behavioural model
   logic [11:0] m_q [$];
   bit          m_ovf, m_ov, m_ed, m_es;
   logic [11:0] m_flit;
   int          m_fc, m_ec;
   bit          m_seen [4];
   int          m_exp  [4];

   function automatic void model_clear();
      m_q.delete();
      m_ovf = 0; m_ov = 0; m_ed = 0; m_es = 0; m_flit = '0;
      m_fc = 0; m_ec = 0;
      for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_exp[i] = 0; end
   endfunction

   function automatic void model_step(input bit w, input logic [11:0] d,
                                      input bit de);
      int          sz, src, seq;
      bit          pop, acc;
      logic [11:0] f;
      sz  = m_q.size();
      pop = de && (sz > 0);
      acc = w && d[0] && (sz < int'(DEPTH));
      if (w && d[0] && sz == int'(DEPTH)) m_ovf = 1;
      m_ov = pop; m_ed = 0; m_es = 0;
      if (pop) begin
         f      = m_q.pop_front();
         m_flit = f;
         src    = int'(f[4:3]);
         seq    = int'(f[11:5]);
         m_ed   = (f[2:1] != MY_ID);
         if (SEQCHK != 0 && m_seen[src] && seq != m_exp[src]) m_es = 1;
         m_seen[src] = 1;
         m_exp[src]  = (seq + 1) % 128;
         m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
         m_ec = (m_ec + int'(m_ed) + int'(m_es) > 65535) ? 65535
                : m_ec + int'(m_ed) + int'(m_es);
      end
      if (acc) m_q.push_back(d);
   endfunction

   // Per-cycle compare against the model
   bit cmp_en      = 0;
   int ov_pulses   = 0;
   int full_cycles = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("full",        32'(bus.full),        32'(m_q.size() == int'(DEPTH)));
         check("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= int'(DEPTH) - 1));
         check("out_valid",   32'(bus.out_valid),   32'(m_ov));
         check("out_flit",    32'(bus.out_flit),    32'(m_flit));
         check("err_dest",    32'(bus.err_dest),    32'(m_ed));
         check("err_seq",     32'(bus.err_seq),     32'(m_es));
         check("overflow",    32'(bus.overflow),    32'(m_ovf));
         check("flit_count",  32'(bus.flit_count),  32'(m_fc));
         check("err_count",   32'(bus.err_count),   32'(m_ec));
         if (bus.out_valid === 1'b1) ov_pulses++;
         if (bus.full === 1'b1) full_cycles++;
      end
   end

   task automatic cycle(input bit w, input logic [11:0] d, input bit de);
      bus.write = w; bus.data_in = d; bus.drain_en = de;
      @(posedge clk);
      model_step(w, d, de);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1; bus.write = 1'b0; bus.drain_en = 1'b0;
      model_clear();
      @(negedge clk);
      check("rst_full",     32'(bus.full),        32'd0);
      check("rst_afull",    32'(bus.almost_full), 32'd0);
      check("rst_overflow", 32'(bus.overflow),    32'd0);
      check("rst_fcount",   32'(bus.flit_count),  32'd0);
      check("rst_ecount",   32'(bus.err_count),   32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_and_pop(input string name, input logic [11:0] f,
                               input int exp_ed, input int exp_es);
      cycle(1'b1, f, 1'b1);
      cycle(1'b0, '0, 1'b1);
      check({name, "_ov"},   32'(bus.out_valid), 32'd1);
      check({name, "_flit"}, 32'(bus.out_flit),  32'(f));
      check({name, "_ed"},   32'(bus.err_dest),  32'(exp_ed));
      check({name, "_es"},   32'(bus.err_seq),   32'(exp_es));
   endtask

   int base_ov, base_full;

   initial begin
      reset = 1'b1; bus.write = 1'b0; bus.data_in = '0; bus.drain_en = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      check("init_full",   32'(bus.full),       32'd0);
      check("init_fcount", 32'(bus.flit_count), 32'd0);
      check("init_ov",     32'(bus.out_valid),  32'd0);
      cmp_en = 1;
      #2 reset = 1'b0;
      @(negedge clk);

      // Streaming: src1 seq 0..9 with continuous drain, plus an invalid strobe
      base_ov = ov_pulses; base_full = full_cycles;
      for (int i = 0; i < 10; i++) cycle(1'b1, mk(i, 1, 0, 1'b1), 1'b1);
      cycle(1'b1, mk(0, 1, 0, 1'b0), 1'b1);
      repeat (3) cycle(1'b0, '0, 1'b1);
      check("stream_pulses", 32'(ov_pulses - base_ov), 32'd10);
      check("stream_fcount", 32'(bus.flit_count),      32'd10);
      check("stream_ecount", 32'(bus.err_count),       32'd0);
      check("stream_nofull", 32'(full_cycles - base_full), 32'd0);

      // Fill to full, overflow, then drain in order
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, mk(i, 3, 0, 1'b1), 1'b0);
         if (i == 6) begin
            check("fill7_afull", 32'(bus.almost_full), 32'd1);
            check("fill7_full",  32'(bus.full),        32'd0);
         end
         if (i == 7) check("fill8_full", 32'(bus.full), 32'd1);
      end
      cycle(1'b1, mk(0, 3, 0, 1'b0), 1'b0);
      check("invalid_no_ovf", 32'(bus.overflow), 32'd0);
      cycle(1'b1, mk(8, 3, 0, 1'b1), 1'b0);
      check("ovf_set", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, '0, 1'b1);
         check("drain_ov",   32'(bus.out_valid), 32'd1);
         check("drain_flit", 32'(bus.out_flit),  32'(mk(i, 3, 0, 1'b1)));
      end
      cycle(1'b0, '0, 1'b1);
      check("drain_empty_ov", 32'(bus.out_valid),  32'd0);
      check("drain_fcount",   32'(bus.flit_count), 32'd18);
      check("ovf_sticky",     32'(bus.overflow),   32'd1);

      // Sequence break on src2
      do_reset();
      send_and_pop("s2_3", mk(3, 2, 0, 1'b1), 0, 0);
      send_and_pop("s2_4", mk(4, 2, 0, 1'b1), 0, 0);
      send_and_pop("s2_6", mk(6, 2, 0, 1'b1), 0, SEQCHK);
      send_and_pop("s2_7", mk(7, 2, 0, 1'b1), 0, 0);
      check("s2_ecount", 32'(bus.err_count), 32'(SEQCHK));

      // Seq wrap on src0, then dest error, then both errors together
      send_and_pop("s0_126", mk(126, 0, 0, 1'b1), 0, 0);
      send_and_pop("s0_127", mk(127, 0, 0, 1'b1), 0, 0);
      send_and_pop("s0_0",   mk(0,   0, 0, 1'b1), 0, 0);
      send_and_pop("s0_1",   mk(1,   0, 0, 1'b1), 0, 0);
      send_and_pop("s0_dst", mk(2,   0, 1, 1'b1), 1, 0);
      check("dst_ecount", 32'(bus.err_count), 32'(SEQCHK + 1));
      send_and_pop("s0_both", mk(9, 0, 1, 1'b1), 1, SEQCHK);
      check("both_ecount", 32'(bus.err_count), 32'(2 * SEQCHK + 2));

      // Reset with stored flits discards them and re-arms the trackers
      for (int i = 0; i < 5; i++) cycle(1'b1, mk(10 + i, 1, 0, 1'b1), 1'b0);
      check("pre_rst_afull", 32'(bus.almost_full), 32'd0);
      do_reset();
      cycle(1'b0, '0, 1'b1);
      check("post_rst_ov", 32'(bus.out_valid), 32'd0);
      send_and_pop("s1_40", mk(40, 1, 0, 1'b1), 0, 0);
      check("post_rst_fcount", 32'(bus.flit_count), 32'd1);

      // Seq gap 3 -> 6 on a fresh source
      do_reset();
      send_and_pop("gap_3", mk(3, 2, 0, 1'b1), 0, 0);
      send_and_pop("gap_6", mk(6, 2, 0, 1'b1), 0, SEQCHK);
      check("gap_ecount", 32'(bus.err_count), 32'(SEQCHK));

      repeat (2) cycle(1'b0, '0, 1'b0);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
